oled_pixel_streamer: RTL



---
 rtl/oled_pkg.sv | 32 +++
 rtl/oled_pixel_streamer_if.sv | 30 +++
 rtl/spi_byte_tx.sv | 92 +++++++++
 rtl/oled_pixel_streamer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED pixel streamer.
//   - Panel geometry defaults and RGB565 colour constants for renderers.
//   - SSD1331 init command list (sent with dc=0 before streaming).
//   - Top-level FSM state encoding.
package oled_pkg;

   localparam int OLED_WIDTH  = 96;
   localparam int OLED_HEIGHT = 64;

   localparam logic [15:0] BLACK = 16'h0000;
   localparam logic [15:0] WHITE = 16'hFFFF;
   localparam logic [15:0] RED   = 16'hF800;
   localparam logic [15:0] GREEN = 16'h07E0;
   localparam logic [15:0] BLUE  = 16'h001F;

   // Display off, remap/colour depth, start line, offset, normal mode,
   // multiplex ratio, master config, column window 0..95, row window 0..63,
   // display on. Index 0 is sent first.
   localparam int INIT_LEN = 19;
   localparam logic [0:INIT_LEN-1][7:0] INIT_ROM = {
      8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4, 8'hA8, 8'h3F,
      8'hAD, 8'h8E, 8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h3F, 8'hAF
   };

   typedef enum logic [1:0] {
      ST_RESET_LOW  = 2'd0,
      ST_RESET_WAIT = 2'd1,
      ST_CMD        = 2'd2,
      ST_STREAM     = 2'd3
   } state_e;

endpackage

// File: rtl/oled_pixel_streamer_if.sv
// Pixel/panel bundle of the OLED streamer.
//   Renderer side : x, y (scan position), oled_data (RGB565 for x,y),
//                   sample_pixel, frame_begin, ready.
//   Pmod side     : cs_n, sclk, mosi, dc, res_n.
// master = the streamer, slave = renderer mux plus panel pins.
interface oled_pixel_streamer_if;
   logic [6:0]  x;
   logic [5:0]  y;
   logic [15:0] oled_data;
   logic        sample_pixel;
   logic        frame_begin;
   logic        ready;
   logic        cs_n;
   logic        sclk;
   logic        mosi;
   logic        dc;
   logic        res_n;

   modport master (
      output x, y, sample_pixel, frame_begin, ready,
      output cs_n, sclk, mosi, dc, res_n,
      input  oled_data
   );

   modport slave (
      input  x, y, sample_pixel, frame_begin, ready,
      input  cs_n, sclk, mosi, dc, res_n,
      output oled_data
   );
endinterface

// File: rtl/spi_byte_tx.sv
// SPI mode 3 byte transmitter, MSB first.
//   start/byte_in : load a byte; accepted when idle or on the done_pulse clk,
//                   so bytes can run back-to-back with no gap.
//   sclk/mosi     : sclk idles high; a byte is 16 half-periods of CLK_DIV clks,
//                   low half first, so the 8th rising edge opens the last half.
//   busy          : byte in flight.
//   done_pulse    : last clk of the byte (combinational).
module spi_byte_tx #(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] byte_in,
   output logic       sclk,
   output logic       mosi,
   output logic       busy,
   output logic       done_pulse
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q, div_d;
   logic [3:0]    half_q, half_d;
   logic [6:0]    sh_q, sh_d;
   logic          sclk_q, sclk_d;
   logic          mosi_q, mosi_d;
   logic          busy_q, busy_d;

   always_comb begin
      div_d      = div_q;
      half_d     = half_q;
      sh_d       = sh_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      busy_d     = busy_q;
      done_pulse = busy_q && (div_q == DIV_LAST) && (half_q == 4'd15);

      if (busy_q) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
            if (half_q == 4'd15) begin
               // leave sclk high; a restart below pulls it low again
               busy_d = 1'b0;
            end else begin
               half_d = half_q + 4'd1;
               sclk_d = ~sclk_q;
               // next bit goes out on the falling edge only
               if (sclk_q) begin
                  mosi_d = sh_q[6];
                  sh_d   = {sh_q[5:0], 1'b0};
               end
            end
         end else begin
            div_d = div_q + 1'b1;
         end
      end

      if (start && (!busy_q || done_pulse)) begin
         busy_d = 1'b1;
         div_d  = '0;
         half_d = 4'd0;
         sclk_d = 1'b0;
         mosi_d = byte_in[7];
         sh_d   = byte_in[6:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         half_q <= 4'd0;
         sh_q   <= 7'd0;
         sclk_q <= 1'b1;
         mosi_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         half_q <= half_d;
         sh_q   <= sh_d;
         sclk_q <= sclk_d;
         mosi_q <= mosi_d;
         busy_q <= busy_d;
      end
   end

   assign sclk = sclk_q;
   assign mosi = mosi_q;
   assign busy = busy_q;

endmodule

// File: rtl/oled_pixel_streamer.sv
// SSD1331 PmodOLEDrgb front end.
//   clk, rst_n : system clock, async active-low reset.
//   bus        : oled_pixel_streamer_if.master (renderer x/y/oled_data,
//                sample/frame strobes, ready, and the Pmod SPI/reset pins).
// Sequence: hold res_n low, wait, send the init list as commands, then
// stream RGB565 pixels forever in raster order, two bytes per pixel.
module oled_pixel_streamer
   import oled_pkg::*;
#(
   parameter int WIDTH      = OLED_WIDTH,
   parameter int HEIGHT     = OLED_HEIGHT,
   parameter int CLK_DIV    = 2,
   parameter int RST_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   oled_pixel_streamer_if.master bus
);

   if (WIDTH > 128 || HEIGHT > 64 || CLK_DIV < 1 || RST_CYCLES < 1) begin : g_bad_param
      $error("oled_pixel_streamer: parameter out of range");
   end

   localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
   localparam logic [4:0]     ROM_END  = 5'(INIT_LEN);
   localparam logic [6:0]     X_LAST   = 7'(WIDTH - 1);
   localparam logic [5:0]     Y_LAST   = 6'(HEIGHT - 1);

   state_e        state_q, state_d;
   logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
   logic [4:0]    rom_idx_q, rom_idx_d;
   logic          byte_sel_q, byte_sel_d;   // 0: next byte is a pixel's high byte
   logic [7:0]    lo_q, lo_d;               // low byte held from the sample clk
   logic [6:0]    x_q, x_d;
   logic [5:0]    y_q, y_d;

   logic       tx_start, tx_busy, tx_done, tx_free, sample;
   logic [7:0] tx_byte;

   assign tx_free = !tx_busy || tx_done;

   always_comb begin
      state_d    = state_q;
      rst_cnt_d  = rst_cnt_q;
      rom_idx_d  = rom_idx_q;
      byte_sel_d = byte_sel_q;
      lo_d       = lo_q;
      x_d        = x_q;
      y_d        = y_q;
      tx_start   = 1'b0;
      tx_byte    = 8'h00;
      sample     = 1'b0;

      case (state_q)
         ST_RESET_LOW, ST_RESET_WAIT: begin
            if (rst_cnt_q == RST_LAST) begin
               rst_cnt_d = '0;
               state_d   = (state_q == ST_RESET_LOW) ? ST_RESET_WAIT : ST_CMD;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end

         ST_CMD: begin
            // cs_n drops one clk before the first byte so it falls with sclk high
            if (tx_free) begin
               if (rom_idx_q != ROM_END) begin
                  tx_start  = 1'b1;
                  tx_byte   = INIT_ROM[rom_idx_q];
                  rom_idx_d = rom_idx_q + 5'd1;
               end else begin
                  state_d = ST_STREAM;
               end
            end
         end

         ST_STREAM: begin
            if (tx_free) begin
               tx_start   = 1'b1;
               byte_sel_d = ~byte_sel_q;
               if (!byte_sel_q) begin
                  // whole pixel is captured here; oled_data is ignored otherwise
                  sample  = 1'b1;
                  tx_byte = bus.oled_data[15:8];
                  lo_d    = bus.oled_data[7:0];
                  if (x_q == X_LAST) begin
                     x_d = 7'd0;
                     y_d = (y_q == Y_LAST) ? 6'd0 : y_q + 6'd1;
                  end else begin
                     x_d = x_q + 7'd1;
                  end
               end else begin
                  tx_byte = lo_q;
               end
            end
         end

         default: state_d = ST_RESET_LOW;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RESET_LOW;
         rst_cnt_q  <= '0;
         rom_idx_q  <= 5'd0;
         byte_sel_q <= 1'b0;
         lo_q       <= 8'h00;
         x_q        <= 7'd0;
         y_q        <= 6'd0;
      end else begin
         state_q    <= state_d;
         rst_cnt_q  <= rst_cnt_d;
         rom_idx_q  <= rom_idx_d;
         byte_sel_q <= byte_sel_d;
         lo_q       <= lo_d;
         x_q        <= x_d;
         y_q        <= y_d;
      end
   end

   spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (tx_start),
      .byte_in   (tx_byte),
      .sclk      (bus.sclk),
      .mosi      (bus.mosi),
      .busy      (tx_busy),
      .done_pulse(tx_done)
   );

   // Pin levels are decoded from the state flop so reset forces them at once.
   assign bus.res_n        = (state_q != ST_RESET_LOW);
   assign bus.cs_n         = (state_q == ST_RESET_LOW) || (state_q == ST_RESET_WAIT);
   assign bus.dc           = (state_q == ST_STREAM);
   assign bus.ready        = (state_q == ST_STREAM);
   assign bus.x            = x_q;
   assign bus.y            = y_q;
   assign bus.sample_pixel = sample;
   assign bus.frame_begin  = sample && (x_q == 7'd0) && (y_q == 6'd0);

endmodule
